// File: rtl/ex_iter_divider_if.sv
// ============================================================================
//  Module : ex_iter_divider_if
//  Brief  : Issue/result bundle between EX pipeline control and the divider.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ex_iter_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic             busy;
    logic             done;
    logic             stall_req;

    modport master (
        output start, is_signed, dividend, divisor, cancel,
        input  div_q, div_r, busy, done, stall_req
    );

    modport slave (
        input  start, is_signed, dividend, divisor, cancel,
        output div_q, div_r, busy, done, stall_req
    );
endinterface

`default_nettype wire

// File: rtl/ex_iter_divider.sv
// ============================================================================
//  Module : ex_iter_divider
//  Brief  : Iterative restoring DIV/DIVU for the EX stage, one bit per cycle.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_iter_divider #(
    parameter int WIDTH = 32
) (
    input  wire             clk,
    input  wire             rst,
    ex_iter_divider_if.slave dif
);

    localparam int               c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_finish;
    logic               w_busy;
    logic               w_done;
    logic               w_stall;

    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic [WIDTH-1:0]   r_dividend;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic               w_last;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_last = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = dif.start;
                // A flush in the same cycle as an issue drops the issue
                if (dif.start && !dif.cancel) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy  = 1'b1;
                w_stall = 1'b1;
                if (dif.cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (dif.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: magnitude restoring division
    // ------------------------------------------------------------------
    assign w_a_mag = (dif.is_signed && dif.dividend[WIDTH-1]) ? (~dif.dividend + 1'b1) : dif.dividend;
    assign w_b_mag = (dif.is_signed && dif.divisor[WIDTH-1])  ? (~dif.divisor + 1'b1)  : dif.divisor;

    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dvsr};
    assign w_rem_nxt = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvsr     <= '0;
            r_dividend <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= w_a_mag;
            r_dvsr     <= w_b_mag;
            r_dividend <= dif.dividend;
            r_neg_q    <= dif.is_signed & (dif.dividend[WIDTH-1] ^ dif.divisor[WIDTH-1]);
            r_neg_r    <= dif.is_signed & dif.dividend[WIDTH-1];
            r_div0     <= (dif.divisor == '0);
        end else if (r_state == S_RUN) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + c_CNT_ONE;
            // Divide by zero bypasses sign fix-up: all-ones quotient, raw dividend
            if (w_finish) begin
                if (r_div0) begin
                    r_q <= '1;
                    r_r <= r_dividend;
                end else begin
                    r_q <= r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
                    r_r <= r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
                end
            end
        end
    end

    assign dif.div_q     = r_q;
    assign dif.div_r     = r_r;
    assign dif.busy      = w_busy;
    assign dif.done      = w_done;
    assign dif.stall_req = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_ex_iter_divider.sv
// ============================================================================
//  Module : tb_ex_iter_divider
//  Brief  : Scoreboard bench for ex_iter_divider with directed DIV/DIVU vectors.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_iter_divider;

    logic clk;
    logic rst;

    ex_iter_divider_if #(.WIDTH(32)) dif ();

    ex_iter_divider #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Result monitor: every done pulse must match the head of the scoreboard
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        if (dif.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_done: got done=1 expected no result (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("div_q", dif.div_q, e.q);
                check("div_r", dif.div_r, e.r);
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        dif.start  = 1'b0;
        dif.cancel = 1'b0;
    endtask

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input bit push);
        exp_t e;
        dif.start     = 1'b1;
        dif.is_signed = s;
        dif.dividend  = a;
        dif.divisor   = b;
        if (push) begin
            e.q   = q;
            e.r   = r;
            e.cyc = cyc + 33;
            sb.push_back(e);
        end
    endtask

    task automatic run(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r);
        @(negedge clk);
        issue(s, a, b, q, r, 1'b1);
        repeat (33) tick();
    endtask

    initial begin
        rst           = 1'b0;
        dif.start     = 1'b0;
        dif.cancel    = 1'b0;
        dif.is_signed = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        repeat (3) @(negedge clk);
        check("rst_q", dif.div_q, 32'h0);
        check("rst_r", dif.div_r, 32'h0);
        check("rst_flags", {29'h0, dif.busy, dif.done, dif.stall_req}, 32'h0);
        rst = 1'b1;

        // DIVU 100/7 with cycle-by-cycle handshake checks
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
        #1;
        check("t1_c0_flags", {29'h0, dif.busy, dif.done, dif.stall_req}, 32'h1);
        for (int k = 1; k <= 33; k++) begin
            tick();
            check("t1_flags", {29'h0, dif.busy, dif.done, dif.stall_req},
                  (k <= 32) ? 32'h5 : 32'h2);
        end

        // Signed truncation, overflow, divide by zero
        run(1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run(1'b1, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'h0);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         32'h8000_0000);
        run(1'b0, 32'd5,         32'h0,          32'hFFFF_FFFF, 32'd5);
        run(1'b1, 32'hFFFF_FFFB, 32'h0,          32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,        32'hFFFF_FFFE);
        run(1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'h0);
        run(1'b0, 32'd100,       32'd7,          32'd14,        32'd2);

        // Start together with cancel in IDLE: dropped, stall still raised
        @(negedge clk);
        issue(1'b0, 32'd9, 32'd4, 32'd0, 32'd0, 1'b0);
        dif.cancel = 1'b1;
        #1;
        check("idle_cancel_stall", {31'h0, dif.stall_req}, 32'h1);
        tick();
        check("idle_cancel_busy", {31'h0, dif.busy}, 32'h0);

        // Cancel on the 10th RUN cycle: no done, results held
        @(negedge clk);
        issue(1'b0, 32'd9, 32'd4, 32'd0, 32'd0, 1'b0);
        repeat (10) tick();
        dif.cancel = 1'b1;
        tick();
        check("cancel_flags", {29'h0, dif.busy, dif.done, dif.stall_req}, 32'h0);
        repeat (30) tick();
        check("cancel_hold_q", dif.div_q, 32'd14);
        check("cancel_hold_r", dif.div_r, 32'd2);

        // Reset on the 5th RUN cycle clears everything
        @(negedge clk);
        issue(1'b1, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_q", dif.div_q, 32'h0);
        check("midrst_r", dif.div_r, 32'h0);
        check("midrst_flags", {29'h0, dif.busy, dif.done, dif.stall_req}, 32'h0);
        repeat (35) tick();

        // Back-to-back issue from the DONE cycle
        @(negedge clk);
        issue(1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 1'b1);
        repeat (33) tick();
        issue(1'b1, 32'd50, 32'd6, 32'd8, 32'd2, 1'b1);
        #1;
        check("done_stall_low", {31'h0, dif.stall_req}, 32'h0);
        tick();
        check("b2b_busy", {31'h0, dif.busy}, 32'h1);
        repeat (32) tick();
        repeat (3) tick();

        check("sb_leftover", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
